// File: rtl/bus_pkg.sv
// Shared bus widths, slave FSM encoding and address-window helper for the SRAM slave.
package bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } slave_state_t;

   // One bit wider than the bus so a window ending at 2^32 does not wrap.
   function automatic logic addr_in_window(input logic [BUS_ADDR_W-1:0] addr,
                                           input logic [BUS_ADDR_W-1:0] base,
                                           input logic [BUS_ADDR_W:0]   span);
      logic [BUS_ADDR_W:0] a_ext;
      logic [BUS_ADDR_W:0] b_ext;
      a_ext = {1'b0, addr};
      b_ext = {1'b0, base};
      return (a_ext >= b_ext) && (a_ext < (b_ext + span));
   endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port synchronous RAM, 32-bit words with byte enables.
// Read-first: a write cycle returns the word as it was before the write.
module sram_1rw_be #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= r_mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/bus_sram_slave.sv
// Valid/ready bus slave fronting an on-chip SRAM with programmable wait states.
// Out-of-window accesses complete normally but return zero, drop writes and pulse o_oob_error.
//
//  state | meaning
//  IDLE  | waiting for i_valid; request fields latched on the accepting edge
//  WAIT  | wait-state down-counter running, terminal count 0 moves to RESP
//  RESP  | o_ready high for this single cycle with read data / oob flag
module bus_sram_slave
   import bus_pkg::*;
#(
   parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int                    DEPTH_WORDS = 1024,
   parameter int                    WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_valid,
   input  logic                  i_instr,
   input  logic [BUS_ADDR_W-1:0] i_addr,
   input  logic [BUS_DATA_W-1:0] i_wdata,
   input  logic [BUS_STRB_W-1:0] i_wstrb,
   output logic                  o_ready,
   output logic [BUS_DATA_W-1:0] o_rdata,
   output logic                  o_oob_error
);

   localparam int                  AW       = $clog2(DEPTH_WORDS);
   localparam logic [BUS_ADDR_W:0] SPAN     = (BUS_ADDR_W+1)'(DEPTH_WORDS) << 2;
   localparam logic [3:0]          CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   slave_state_t          r_state;
   slave_state_t          w_next;
   logic [3:0]            r_cnt;
   logic [AW-1:0]         r_idx;
   logic [BUS_DATA_W-1:0] r_wdata;
   logic [BUS_STRB_W-1:0] r_wstrb;
   logic                  r_in_range;

   logic                  w_acc;
   logic [AW-1:0]         w_bus_idx;
   logic                  w_bus_in_range;
   logic [AW-1:0]         w_mem_idx;
   logic [BUS_DATA_W-1:0] w_mem_wdata;
   logic [BUS_STRB_W-1:0] w_mem_wstrb;
   logic                  w_mem_in_range;
   logic                  w_enter_resp;
   logic [BUS_STRB_W-1:0] w_mem_we;
   logic [BUS_DATA_W-1:0] w_sram_rdata;
   logic                  w_unused;

   // Fetches are served exactly like data reads.
   assign w_unused       = i_instr;

   assign w_acc          = (r_state == IDLE) && i_valid;
   assign w_bus_idx      = AW'((i_addr - BASE_ADDR) >> 2);
   assign w_bus_in_range = addr_in_window(i_addr, BASE_ADDR, SPAN);

   // With zero wait states the SRAM is accessed on the accepting edge, before the latches are loaded.
   assign w_mem_idx      = (r_state == IDLE) ? w_bus_idx      : r_idx;
   assign w_mem_wdata    = (r_state == IDLE) ? i_wdata        : r_wdata;
   assign w_mem_wstrb    = (r_state == IDLE) ? i_wstrb        : r_wstrb;
   assign w_mem_in_range = (r_state == IDLE) ? w_bus_in_range : r_in_range;
   assign w_enter_resp   = (w_next == RESP);
   assign w_mem_we       = (w_enter_resp && w_mem_in_range) ? w_mem_wstrb : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_in_range <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_cnt      <= CNT_LOAD;
            r_idx      <= w_bus_idx;
            r_wdata    <= i_wdata;
            r_wstrb    <= i_wstrb;
            r_in_range <= w_bus_in_range;
         end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_valid) begin
               w_next = (WAIT_STATES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next = RESP;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_ready     = 1'b0;
      o_rdata     = '0;
      o_oob_error = 1'b0;
      if (r_state == RESP) begin
         o_ready     = 1'b1;
         o_oob_error = !r_in_range;
         if ((r_wstrb == '0) && r_in_range) begin
            o_rdata = w_sram_rdata;
         end
      end
   end

   sram_1rw_be #(
      .DEPTH (DEPTH_WORDS)
   ) u_sram (
      .clk   (clk),
      .en    (w_enter_resp),
      .we    (w_mem_we),
      .addr  (w_mem_idx),
      .wdata (w_mem_wdata),
      .rdata (w_sram_rdata)
   );

   // The master must hold valid until it sees ready.
   a_valid_held: assert property (@(posedge clk) disable iff (!resetn)
                                  (r_state == WAIT) |-> i_valid);

endmodule
